// File: rtl/sop_sweep_checker.sv
// Sweeps every input vector of an N-variable minimized SOP block and compares its
// output F against a latched truth-table mask, collecting pass/fail statistics.
module sop_sweep_checker #(
    parameter int NUM_VARS      = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2**NUM_VARS-1:0]   expected_mask,
    input  logic                     f_in,
    output logic [NUM_VARS-1:0]      vec_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [NUM_VARS:0]        err_count,
    output logic [2**NUM_VARS-1:0]   fail_mask,
    output logic [NUM_VARS-1:0]      first_fail_vec
);

    localparam int NUM_VECS = 2**NUM_VARS;
    localparam int CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [NUM_VARS-1:0] LAST_VEC    = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [NUM_VECS-1:0]  latched_mask;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 sample;
    logic                 mismatch;

    always_comb begin
        sample    = 1'b0;
        mismatch  = 1'b0;
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                sample   = !abort && (settle_cnt == '0);
                mismatch = sample && (f_in != latched_mask[vec_out]);
                if (abort)
                    state_nxt = IDLE;
                else if (sample && vec_out == LAST_VEC)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_out        <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_mask      <= '0;
            first_fail_vec <= '0;
            latched_mask   <= '0;
            settle_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        latched_mask   <= expected_mask;
                        err_count      <= '0;
                        fail_mask      <= '0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        vec_out        <= '0;
                        settle_cnt     <= SETTLE_LOAD;
                    end
                end
                RUN: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end else begin
                        if (mismatch) begin
                            err_count          <= err_count + (NUM_VARS+1)'(1);
                            fail_mask[vec_out] <= 1'b1;
                            if (err_count == '0) first_fail_vec <= vec_out;
                        end
                        // Verdict is formed here so it already reflects the final sample.
                        if (vec_out == LAST_VEC) begin
                            pass <= (err_count == '0) && !mismatch;
                        end else begin
                            vec_out    <= vec_out + NUM_VARS'(1);
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Directed + randomized bench for sop_sweep_checker with a truth-table reference model.
module tb_sop_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, start0, abort0;
    logic [15:0] expected_mask, expected_mask0, f_tbl, f_tbl0;
    logic        f_in, f_in0;
    logic [3:0]  vec_out, vec_out0, first_fail_vec, first_fail_vec0;
    logic        busy, done, pass, busy0, done0, pass0;
    logic [4:0]  err_count, err_count0;
    logic [15:0] fail_mask, fail_mask0;

    int checks = 0;
    int errors = 0;

    // behavioural stand-ins for the minimized-logic instances
    assign f_in  = f_tbl[vec_out];
    assign f_in0 = f_tbl0[vec_out0];

    sop_sweep_checker #(.NUM_VARS(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .expected_mask(expected_mask), .f_in(f_in), .vec_out(vec_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .first_fail_vec(first_fail_vec)
    );

    sop_sweep_checker #(.NUM_VARS(4), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .expected_mask(expected_mask0), .f_in(f_in0), .vec_out(vec_out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .fail_mask(fail_mask0), .first_fail_vec(first_fail_vec0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount16(input logic [15:0] x);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(x[i]);
        return c;
    endfunction

    function automatic int lowest_set(input logic [15:0] x);
        for (int i = 0; i < 16; i++) if (x[i]) return i;
        return 0;
    endfunction

    // Full sweep on one instance; settle = 1 (dut) or 0 (dut0).
    task automatic sweep(input string tag, input bit use0, input logic [15:0] m, input logic [15:0] tbl);
        int per, last, dones, done_at, nerr;
        logic [15:0] diff;
        per = use0 ? 1 : 2;
        last = 16 * per + 1;
        dones = 0;
        done_at = 0;
        if (use0) begin expected_mask0 = m; f_tbl0 = tbl; start0 = 1'b1; end
        else      begin expected_mask  = m; f_tbl  = tbl; start  = 1'b1; end
        tick();
        start = 1'b0;
        start0 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n <= last) begin
                int ev = (n - 1) / per;
                if (ev > 15) ev = 15;
                chk($sformatf("%s_vec_c%0d", tag, n), use0 ? vec_out0 : vec_out, ev);
            end
            if (use0 ? done0 : done) begin
                dones++;
                if (done_at == 0) done_at = n;
            end
            tick();
        end
        diff = m ^ tbl;
        nerr = popcount16(diff);
        chk({tag, "_done_cnt"}, dones, 1);
        chk({tag, "_done_at"}, done_at, last);
        chk({tag, "_err"}, use0 ? err_count0 : err_count, nerr);
        chk({tag, "_fmask"}, use0 ? fail_mask0 : fail_mask, diff);
        chk({tag, "_ffv"}, use0 ? first_fail_vec0 : first_fail_vec, lowest_set(diff));
        chk({tag, "_pass"}, use0 ? pass0 : pass, nerr == 0);
        chk({tag, "_busy"}, use0 ? busy0 : busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec"}, vec_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_fmask"}, fail_mask, 0);
        chk({tag, "_ffv"}, first_fail_vec, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, dones, done_at;
        logic [15:0] m, t;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        expected_mask = '0; expected_mask0 = '0; f_tbl = '0; f_tbl0 = '0;
        repeat (2) tick();
        chk_reset_outputs("rst0");
        chk("rst0_busy0", busy0, 0);
        chk("rst0_err0", err_count0, 0);
        rst = 1'b0;
        tick();

        sweep("tied0", 0, 16'h0000, 16'h0000);
        sweep("tied1", 0, 16'h0000, 16'hFFFF);
        sweep("m4a2c", 0, 16'h4A2C, 16'h4A2C);
        sweep("m482c", 0, 16'h482C, 16'h4A2C);

        // start held, extra pulse, mask changed mid-run: one sweep only
        expected_mask = 16'h0000; f_tbl = 16'h0000; start = 1'b1;
        tick();
        dones = 0; done_at = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) expected_mask = 16'hFFFF;
            if (n == 9) start = 1'b0;
            if (n == 10) start = 1'b1;
            if (done) begin
                dones++;
                if (done_at == 0) done_at = n;
                start = 1'b0;
            end
            tick();
        end
        chk("hold_done_cnt", dones, 1);
        chk("hold_done_at", done_at, 33);
        chk("hold_busy", busy, 0);
        chk("hold_pass", pass, 1);
        chk("hold_err", err_count, 0);

        // abort at vec 5 keeps partial statistics
        expected_mask = 16'h0000; f_tbl = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (vec_out !== 4'd5 && w < 40) begin tick(); w++; end
        chk("abort_reach", vec_out, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_err", err_count, 5);
        chk("abort_fmask", fail_mask, 16'h001F);
        chk("abort_vec", vec_out, 5);
        tick();
        chk("abort_done2", done, 0);
        chk("abort_busy2", busy, 0);
        sweep("post_abort", 0, 16'h0000, 16'h0000);

        // asynchronous reset mid-sweep at vec 7
        expected_mask = 16'h0000; f_tbl = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (vec_out !== 4'd7 && w < 40) begin tick(); w++; end
        chk("arst_reach", vec_out, 7);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("arst");
        #1 rst = 1'b0;
        tick();
        chk("arst_busy_after", busy, 0);
        chk("arst_done_after", done, 0);
        sweep("post_rst", 0, 16'h0000, 16'h0000);

        // randomized truth tables with sparse faults
        for (int i = 0; i < 4; i++) begin
            m = 16'($urandom);
            t = m ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            sweep($sformatf("rnd%0d", i), 0, m, t);
        end

        // zero settle cycles
        sweep("s0_clean", 1, 16'h4A2C, 16'h4A2C);
        for (int i = 0; i < 2; i++) begin
            m = 16'($urandom);
            t = m ^ (16'($urandom) & 16'($urandom));
            sweep($sformatf("s0_rnd%0d", i), 1, m, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
